// File: rtl/pio_shift_out_if.sv
// Pin bundle towards a 74HC595-style external shift register.
// The master drives the shift clock, serial data and storage latch;
// the slave (board header side / monitor) only observes them.
interface pio_shift_out_if;
    logic sr_sclk;
    logic sr_sdata;
    logic sr_latch;

    modport master (
        output sr_sclk,
        output sr_sdata,
        output sr_latch
    );

    modport slave (
        input sr_sclk,
        input sr_sdata,
        input sr_latch
    );
endinterface

// File: rtl/pio_shift_out.sv
// pio_shift_out: serialises the Nios II 8-bit PIO export onto an external
// 74HC595-style shift register (data, shift clock, latch strobe).
// A transfer is started after reset and whenever the PIO value differs from
// the last value sent; changes arriving mid-transfer are coalesced so the
// newest value is sent next.
// Optional feature macro: PIO_SHIFT_REFRESH_EN -- when defined, an IDLE
// cycle counter forces a retransmit of the unchanged value every
// REFRESH_CYCLES idle cycles to recover from glitches on the external part.
module pio_shift_out #(
    parameter int DATA_W         = 8,
    parameter int CLK_DIV        = 4,
    parameter int MSB_FIRST      = 1,
    parameter int REFRESH_CYCLES = 50000000
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [DATA_W-1:0]  pio_data_in,
    pio_shift_out_if.master    sr,
    output logic               busy,
    output logic [15:0]        xfer_count
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0]  last_sent_q, last_sent_d;
    logic               init_pending_q, init_pending_d;
    logic [7:0]         div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [15:0]        xfer_q, xfer_d;

    logic               sclk_q, sdata_q, latch_q, busy_q;

    logic [DATA_W-1:0]  shreg_shifted;
    logic               first_bit_d;
    logic               div_done;
    logic               trigger;
    logic               refresh_hit;

    assign div_done = (div_q == DIV_LAST);

    // Shift direction is fixed at elaboration: the bit on the pins is always
    // the "front" end of the shift register, and shifting moves the next bit
    // into that position.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign first_bit_d   = shreg_d[DATA_W-1];
            assign shreg_shifted = shreg_q << 1;
        end else begin : g_lsb_first
            assign first_bit_d   = shreg_d[0];
            assign shreg_shifted = shreg_q >> 1;
        end
    endgenerate

`ifdef PIO_SHIFT_REFRESH_EN
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] refresh_q;

    assign refresh_hit = (state_q == S_IDLE) && (refresh_q == REFRESH_LAST);

    // Idle-cycle counter: runs only while IDLE, restarts after each refresh
    // and whenever a transfer is in progress.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            refresh_q <= '0;
        end else if (state_q != S_IDLE || refresh_hit) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_q + RW'(1);
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    // The refresh hit counts as a pending init so the retransmit starts on
    // the same cycle the counter expires.
    assign trigger = (pio_data_in != last_sent_q) || init_pending_q || refresh_hit;

    // Next-state and datapath update for the transfer sequencer.
    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        last_sent_d    = last_sent_q;
        init_pending_d = init_pending_q;
        div_d          = div_q;
        bit_d          = bit_q;
        xfer_d         = xfer_q;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (refresh_hit) begin
                    init_pending_d = 1'b1;
                end
                if (trigger) begin
                    // The word is captured on the edge into LOAD so that the
                    // first bit is already on sr_sdata during the LOAD cycle.
                    state_d        = S_LOAD;
                    shreg_d        = pio_data_in;
                    last_sent_d    = pio_data_in;
                    init_pending_d = 1'b0;
                    bit_d          = BIT_LAST;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT_LO;
                div_d   = '0;
            end
            S_SHIFT_LO: begin
                if (div_done) begin
                    div_d   = '0;
                    state_d = S_SHIFT_HI;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_SHIFT_HI: begin
                if (div_done) begin
                    div_d = '0;
                    if (bit_q != '0) begin
                        shreg_d = shreg_shifted;
                        bit_d   = bit_q - BIT_W'(1);
                        state_d = S_SHIFT_LO;
                    end else begin
                        state_d = S_LATCH;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_LATCH: begin
                if (div_done) begin
                    div_d   = '0;
                    xfer_d  = xfer_q + 16'd1;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
        endcase
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q        <= S_IDLE;
            shreg_q        <= '0;
            last_sent_q    <= '0;
            init_pending_q <= 1'b1;
            div_q          <= '0;
            bit_q          <= '0;
            xfer_q         <= '0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            last_sent_q    <= last_sent_d;
            init_pending_q <= init_pending_d;
            div_q          <= div_d;
            bit_q          <= bit_d;
            xfer_q         <= xfer_d;
        end
    end

    // Pin registers are decoded from the next state so every output changes
    // exactly on the edge that enters the corresponding state.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sclk_q  <= (state_d == S_SHIFT_HI);
            sdata_q <= (state_d != S_IDLE) && first_bit_d;
            latch_q <= (state_d == S_LATCH);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign sr.sr_sclk  = sclk_q;
    assign sr.sr_sdata = sdata_q;
    assign sr.sr_latch = latch_q;
    assign busy        = busy_q;
    assign xfer_count  = xfer_q;

endmodule

// File: tb/tb_pio_shift_out.sv
// Directed bench for pio_shift_out: a default MSB-first / CLK_DIV=4 instance
// and an LSB-first / CLK_DIV=1 instance share one clock. A negedge monitor
// reconstructs the shifted bits and measures busy, latch and idle lengths.
module tb_pio_shift_out;

    logic        clk = 1'b0;
    logic        rst0_n = 1'b0;
    logic        rst1_n = 1'b0;
    logic [7:0]  pio0 = 8'h00;
    logic [7:0]  pio1 = 8'h01;
    logic        busy0, busy1;
    logic [15:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pio_shift_out_if sr0 ();
    pio_shift_out_if sr1 ();

    pio_shift_out #(
        .DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1), .REFRESH_CYCLES(100)
    ) dut0 (
        .clk_clk(clk), .reset_reset_n(rst0_n), .pio_data_in(pio0),
        .sr(sr0), .busy(busy0), .xfer_count(cnt0)
    );

    pio_shift_out #(
        .DATA_W(8), .CLK_DIV(1), .MSB_FIRST(0), .REFRESH_CYCLES(100000)
    ) dut1 (
        .clk_clk(clk), .reset_reset_n(rst1_n), .pio_data_in(pio1),
        .sr(sr1), .busy(busy1), .xfer_count(cnt1)
    );

    logic [1:0] m_sclk, m_sdata, m_latch, m_busy;
    assign m_sclk  = {sr1.sr_sclk,  sr0.sr_sclk};
    assign m_sdata = {sr1.sr_sdata, sr0.sr_sdata};
    assign m_latch = {sr1.sr_latch, sr0.sr_latch};
    assign m_busy  = {busy1, busy0};

    int cyc = 0;
    int edges_run [2], last_edges [2];
    int busy_run [2], last_busy_len [2];
    int latch_run [2], last_latch_len [2];
    int idle_run [2], last_idle_len [2];
    int falls [2], latch_rises [2], rise_cyc [2], latch_cyc [2];
    logic [7:0] cap [2], last_val [2], prev_val [2];
    logic [1:0] sclk_p = '0, latch_p = '0, busy_p = '0;

    // Monitor: bits are shifted into cap in the order they are sampled at
    // sclk rising edges, so an MSB-first transfer reproduces the word.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i] && !busy_p[i]) begin
                edges_run[i]     = 0;
                last_idle_len[i] = idle_run[i];
            end
            if (m_sclk[i] && !sclk_p[i]) begin
                cap[i] = {cap[i][6:0], m_sdata[i]};
                edges_run[i]++;
                rise_cyc[i] = cyc;
            end
            if (m_latch[i] && !latch_p[i]) begin
                latch_rises[i]++;
                latch_cyc[i] = cyc;
            end
            if (m_latch[i]) begin
                latch_run[i]++;
            end else if (latch_p[i]) begin
                last_latch_len[i] = latch_run[i];
                latch_run[i]      = 0;
            end
            if (m_busy[i]) begin
                busy_run[i]++;
                idle_run[i] = 0;
            end else begin
                if (busy_p[i]) begin
                    last_busy_len[i] = busy_run[i];
                    last_edges[i]    = edges_run[i];
                    busy_run[i]      = 0;
                    falls[i]++;
                    prev_val[i] = last_val[i];
                    last_val[i] = cap[i];
                    $display("xfer dut%0d value=0x%02h busy_len=%0d edges=%0d",
                             i, cap[i], last_busy_len[i], last_edges[i]);
                end
                idle_run[i]++;
            end
            sclk_p[i]  = m_sclk[i];
            latch_p[i] = m_latch[i];
            busy_p[i]  = m_busy[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_falls(input int i, input int target, input int budget, input string tag);
        int k = 0;
        while (falls[i] < target && k < budget) begin
            step(1);
            k++;
        end
        check({tag, "_timeout"}, 32'(falls[i] >= target), 32'd1);
    endtask

    task automatic wait_busy_run(input int i, input int n, input int budget, input string tag);
        int k = 0;
        while (busy_run[i] < n && k < budget) begin
            step(1);
            k++;
        end
        check({tag, "_timeout"}, 32'(busy_run[i] >= n), 32'd1);
    endtask

    int base;
    int lr;

    initial begin
        // Reset state
        step(3);
        check("rst0_outputs", {m_sclk[0], m_sdata[0], m_latch[0], m_busy[0], cnt0}, 32'd0);
        check("rst1_outputs", {m_sclk[1], m_sdata[1], m_latch[1], m_busy[1], cnt1}, 32'd0);

        // Power-up forced transfer on both instances
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        wait_falls(0, 1, 200, "pwr0");
        check("pwr0_value",     32'(last_val[0]),      32'h00);
        check("pwr0_edges",     32'(last_edges[0]),    32'd8);
        check("pwr0_busy_len",  32'(last_busy_len[0]), 32'd69);
        check("pwr0_latch_len", 32'(last_latch_len[0]), 32'd4);
        check("pwr0_count",     32'(cnt0),             32'd1);
        check("lsb_pwr_value",    32'(last_val[1]),      32'h80);
        check("lsb_pwr_busy_len", 32'(last_busy_len[1]), 32'd18);
        check("lsb_pwr_count",    32'(cnt1),             32'd1);
        step(60);
        check("pwr0_no_second", 32'(falls[0]), 32'd1);
        check("pwr0_count_hold", 32'(cnt0),    32'd1);

        // LSB-first fast instance: 0x80 arrives last-bit-first
        pio1 = 8'h80;
        wait_falls(1, 2, 100, "lsb80");
        check("lsb80_value",     32'(last_val[1]),       32'h01);
        check("lsb80_edges",     32'(last_edges[1]),     32'd8);
        check("lsb80_busy_len",  32'(last_busy_len[1]),  32'd18);
        check("lsb80_latch_len", 32'(last_latch_len[1]), 32'd1);
        check("lsb80_latch_gap", 32'(latch_cyc[1] - rise_cyc[1]), 32'd1);
        check("lsb80_count",     32'(cnt1),              32'd2);

        // Single change, MSB first
        base = falls[0];
        pio0 = 8'hA5;
        wait_falls(0, base + 1, 200, "a5");
        check("a5_value",     32'(last_val[0]),      32'hA5);
        check("a5_busy_len",  32'(last_busy_len[0]), 32'd69);
        check("a5_latch_gap", 32'(latch_cyc[0] - rise_cyc[0]), 32'd4);
        check("a5_count",     32'(cnt0),             32'd2);

        // Coalescing: 0x11 is superseded by 0xF0 before 0x3C finishes
        base = falls[0];
        pio0 = 8'h3C;
        wait_busy_run(0, 1, 20, "coal_start");
        step(10);
        pio0 = 8'h11;
        step(5);
        pio0 = 8'hF0;
        wait_falls(0, base + 2, 400, "coal");
        check("coal_first",  32'(prev_val[0]), 32'h3C);
        check("coal_second", 32'(last_val[0]), 32'hF0);
        check("coal_count",  32'(cnt0),        32'd4);
        step(60);
        check("coal_no_third", 32'(falls[0] - base), 32'd2);

        // Mid-transfer reset
        pio0 = 8'h77;
        wait_busy_run(0, 30, 200, "mid_start");
        lr = latch_rises[0];
        rst0_n = 1'b0;
        #1;
        check("mid_async_clear", {m_sclk[0], m_sdata[0], m_latch[0], m_busy[0], cnt0}, 32'd0);
        step(8);
        check("mid_no_latch", 32'(latch_rises[0] - lr), 32'd0);
        check("mid_still_clear", {m_sclk[0], m_sdata[0], m_latch[0], m_busy[0], cnt0}, 32'd0);
        base = falls[0];
        rst0_n = 1'b1;
        wait_falls(0, base + 1, 200, "mid_rerun");
        check("mid_value",    32'(last_val[0]),      32'h77);
        check("mid_busy_len", 32'(last_busy_len[0]), 32'd69);
        check("mid_count",    32'(cnt0),             32'd1);

        // Refresh behaviour with an unchanged value
        base = falls[0];
        pio0 = 8'h5A;
        wait_falls(0, base + 1, 200, "ref_first");
        check("ref_first_value", 32'(last_val[0]), 32'h5A);
`ifdef PIO_SHIFT_REFRESH_EN
        wait_falls(0, base + 2, 300, "ref_retx");
        check("ref_idle_gap", 32'(last_idle_len[0]), 32'd100);
        check("ref_value",    32'(last_val[0]),      32'h5A);
        check("ref_count",    32'(cnt0),             32'd3);
`else
        step(250);
        check("ref_none",       32'(falls[0] - base), 32'd1);
        check("ref_none_count", 32'(cnt0),            32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
